// File: rtl/csr_access_master.sv
// csr_access_master: single-outstanding initiator for a strobe-based CSR bus.
// Accepts READ / WRITE / SET / CLR requests over valid/ready. It drives one-cycle
// csr_read/csr_write strobes and captures read data a fixed RD_LATENCY edges later.
// The response is returned over valid/ready.
module csr_access_master #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              csr_read,
    output logic [ADDR_W-1:0] csr_read_addr,
    input  logic [DATA_W-1:0] csr_read_data,
    output logic              csr_write,
    output logic [ADDR_W-1:0] csr_write_addr,
    output logic [DATA_W-1:0] csr_write_data,
    output logic [CNT_W-1:0]  txn_count
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RMW_WR, RSP} state_t;

    state_t            state, state_n;
    logic [1:0]        op_q, op_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [2:0]        lat_q, lat_n;
    logic              rsp_valid_n, csr_read_n, csr_write_n;
    logic [DATA_W-1:0] rsp_rdata_n, csr_write_data_n;
    logic [ADDR_W-1:0] csr_read_addr_n, csr_write_addr_n;
    logic [CNT_W-1:0]  txn_count_n;

    // Only IDLE takes a new request; everything else is a single transaction in flight.
    assign req_ready = (state == IDLE);

    // Next-state and next-output logic; strobes default low so each lasts one cycle.
    always_comb begin
        state_n          = state;
        op_n             = op_q;
        wdata_n          = wdata_q;
        lat_n            = lat_q;
        rsp_valid_n      = rsp_valid;
        rsp_rdata_n      = rsp_rdata;
        csr_read_n       = 1'b0;
        csr_read_addr_n  = csr_read_addr;
        csr_write_n      = 1'b0;
        csr_write_addr_n = csr_write_addr;
        csr_write_data_n = csr_write_data;
        txn_count_n      = txn_count;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n    = req_op;
                    wdata_n = req_wdata;
                    if (req_op == OP_WRITE) begin
                        csr_write_n      = 1'b1;
                        csr_write_addr_n = req_addr;
                        csr_write_data_n = req_wdata;
                        state_n          = WR;
                    end else begin
                        csr_read_n      = 1'b1;
                        csr_read_addr_n = req_addr;
                        lat_n           = 3'(RD_LATENCY);
                        state_n         = RD_WAIT;
                    end
                end
            end
            WR: begin
                rsp_valid_n = 1'b1;
                rsp_rdata_n = wdata_q;
                state_n     = RSP;
            end
            RD_WAIT: begin
                // Counter hits zero on the edge RD_LATENCY edges after the strobe was seen.
                if (lat_q == 3'd0) begin
                    rsp_rdata_n = csr_read_data;
                    if (op_q == OP_READ) begin
                        rsp_valid_n = 1'b1;
                        state_n     = RSP;
                    end else begin
                        csr_write_n      = 1'b1;
                        csr_write_addr_n = csr_read_addr;
                        csr_write_data_n = (op_q == OP_SET) ? (csr_read_data | wdata_q)
                                                            : (csr_read_data & ~wdata_q);
                        state_n          = RMW_WR;
                    end
                end else begin
                    lat_n = lat_q - 3'd1;
                end
            end
            RMW_WR: begin
                rsp_valid_n = 1'b1;
                state_n     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    txn_count_n = txn_count + 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            wdata_q        <= '0;
            lat_q          <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            csr_read       <= 1'b0;
            csr_read_addr  <= '0;
            csr_write      <= 1'b0;
            csr_write_addr <= '0;
            csr_write_data <= '0;
            txn_count      <= '0;
        end else begin
            state          <= state_n;
            op_q           <= op_n;
            wdata_q        <= wdata_n;
            lat_q          <= lat_n;
            rsp_valid      <= rsp_valid_n;
            rsp_rdata      <= rsp_rdata_n;
            csr_read       <= csr_read_n;
            csr_read_addr  <= csr_read_addr_n;
            csr_write      <= csr_write_n;
            csr_write_addr <= csr_write_addr_n;
            csr_write_data <= csr_write_data_n;
            txn_count      <= txn_count_n;
        end
    end

endmodule

// File: tb/tb_csr_access_master.sv
// Bench for csr_access_master. Two instances are used: d=0 (RD_LATENCY=1, CNT_W=16)
// and d=1 (RD_LATENCY=3, CNT_W=2). Each has its own CSR responder and a
// transaction-level model of the register contents.
module tb_csr_access_master;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam logic [1:0] RD = 2'b00, WRT = 2'b01, SETB = 2'b10, CLRB = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req_valid, req_ready, rsp_valid, rsp_ready, csr_read, csr_write;
    logic [1:0][1:0]  req_op;
    logic [1:0][11:0] req_addr, csr_read_addr, csr_write_addr;
    logic [1:0][31:0] req_wdata, rsp_rdata, csr_read_data, csr_write_data;
    logic [15:0]      tc0;
    logic [1:0]       tc1;

    csr_access_master #(.ADDR_W(12), .DATA_W(32), .RD_LATENCY(LAT0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .csr_read(csr_read[0]), .csr_read_addr(csr_read_addr[0]), .csr_read_data(csr_read_data[0]),
        .csr_write(csr_write[0]), .csr_write_addr(csr_write_addr[0]),
        .csr_write_data(csr_write_data[0]), .txn_count(tc0));

    csr_access_master #(.ADDR_W(12), .DATA_W(32), .RD_LATENCY(LAT1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .csr_read(csr_read[1]), .csr_read_addr(csr_read_addr[1]), .csr_read_data(csr_read_data[1]),
        .csr_write(csr_write[1]), .csr_write_addr(csr_write_addr[1]),
        .csr_write_data(csr_write_data[1]), .txn_count(tc1));

    // CSR responders: storage plus a read pipeline; slots without a read carry junk.
    bit   [31:0] dev_mem [2][4096];
    logic [31:0] rd_pipe [2][8];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (csr_write[d]) dev_mem[d][csr_write_addr[d]] <= csr_write_data[d];
            rd_pipe[d][0] <= csr_read[d] ? dev_mem[d][csr_read_addr[d]] : $urandom;
            for (int k = 1; k < 8; k++) rd_pipe[d][k] <= rd_pipe[d][k-1];
        end
    end
    assign csr_read_data[0] = rd_pipe[0][LAT0-1];
    assign csr_read_data[1] = rd_pipe[1][LAT1-1];

    // Strobe monitor: running totals that the stimulus diffs per transaction.
    int          rd_cnt [2];
    int          wr_cnt [2];
    int          ovl_cnt[2];
    logic [11:0] last_raddr[2], last_waddr[2];
    logic [31:0] last_wdata[2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (csr_read[d]) begin
                rd_cnt[d]     <= rd_cnt[d] + 1;
                last_raddr[d] <= csr_read_addr[d];
            end
            if (csr_write[d]) begin
                wr_cnt[d]     <= wr_cnt[d] + 1;
                last_waddr[d] <= csr_write_addr[d];
                last_wdata[d] <= csr_write_data[d];
            end
            if (csr_read[d] && csr_write[d]) ovl_cnt[d] <= ovl_cnt[d] + 1;
        end
    end

    // Reference model: register contents and completed-response count.
    bit [31:0] mdl_mem [2][4096];
    int        mdl_cnt [2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int d);
        return (d == 1) ? int'(tc1) : int'(tc0);
    endfunction

    task automatic drive_req(input int d, input logic v, input logic [1:0] op,
                             input logic [11:0] a, input logic [31:0] wd);
        req_valid[d] = v;
        req_op[d]    = op;
        req_addr[d]  = a;
        req_wdata[d] = wd;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid[d], 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata[d], 0);
        chk({tag, "_strobes"}, {csr_read[d], csr_write[d]}, 0);
        chk({tag, "_addrs"}, {csr_read_addr[d], csr_write_addr[d]}, 0);
        chk({tag, "_wdata"}, csr_write_data[d], 0);
        chk({tag, "_count"}, cnt_of(d), 0);
    endtask

    // One transaction, entered and left just after a falling edge. While busy the request
    // inputs carry junk, or the next request when nv is set, so it is accepted the edge
    // right after this handshake.
    task automatic do_txn(input int d, input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] wd, input int hold, input logic nv,
                          input logic [1:0] nop, input logic [11:0] na, input logic [31:0] nwd,
                          output logic [31:0] got_rd, output logic [31:0] got_wd);
        int          r0, w0, o0, lat, exp_lat, L;
        logic [31:0] old, exp_rd, new_v, held;
        L       = (d == 1) ? LAT1 : LAT0;
        old     = mdl_mem[d][a];
        exp_rd  = (op == WRT) ? wd : old;
        new_v   = (op == WRT) ? wd : (op == SETB) ? (old | wd) : (op == CLRB) ? (old & ~wd) : old;
        exp_lat = (op == WRT) ? 1 : (op == RD) ? 1 + L : 2 + L;
        r0 = rd_cnt[d]; w0 = wr_cnt[d]; o0 = ovl_cnt[d];
        chk("req_ready_idle", req_ready[d], 1);
        drive_req(d, 1'b1, op, a, wd);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            if (nv) drive_req(d, 1'b1, nop, na, nwd);
            else    drive_req(d, 1'($urandom), 2'($urandom), 12'($urandom), $urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, exp_lat);
        chk("rsp_rdata", rsp_rdata[d], exp_rd);
        got_rd = rsp_rdata[d];
        held   = rsp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            if (nv) drive_req(d, 1'b1, nop, na, nwd);
            else    drive_req(d, 1'b1, 2'($urandom), 12'($urandom), $urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", rsp_valid[d], 1);
            chk("hold_rdata", rsp_rdata[d], held);
            chk("hold_req_ready", req_ready[d], 0);
        end
        rsp_ready[d] = 1'b1;
        if (nv) drive_req(d, 1'b1, nop, na, nwd);
        else    drive_req(d, 1'b0, 2'($urandom), 12'($urandom), $urandom);
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        mdl_cnt[d]++;
        mdl_mem[d][a] = new_v;
        chk("rsp_dropped", rsp_valid[d], 0);
        chk("req_ready_after", req_ready[d], 1);
        chk("txn_count", cnt_of(d), (d == 1) ? (mdl_cnt[d] % 4) : (mdl_cnt[d] % 65536));
        chk("rd_pulses", rd_cnt[d] - r0, (op == WRT) ? 0 : 1);
        chk("wr_pulses", wr_cnt[d] - w0, (op == RD) ? 0 : 1);
        chk("overlap", ovl_cnt[d] - o0, 0);
        if (op != RD)  chk("wr_addr", last_waddr[d], a);
        if (op != WRT) chk("rd_addr", last_raddr[d], a);
        got_wd = (op == RD) ? 32'h0 : last_wdata[d];
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
        bit          has_wr;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] grd, gwd;
    int          r0, w0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{WRT,  12'h010, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        tbl[1] = '{RD,   12'h010, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[2] = '{WRT,  12'h020, 32'h000000F0, 32'h000000F0, 32'h000000F0, 1'b1};
        tbl[3] = '{SETB, 12'h020, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b1};
        tbl[4] = '{CLRB, 12'h020, 32'h00000030, 32'h000000FF, 32'h000000CF, 1'b1};

        rst = 2'b11;
        rsp_ready = 2'b00;
        for (int d = 0; d < 2; d++) drive_req(d, 1'b0, 2'b00, 12'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst = 2'b00;

        // Directed write / read / set / clear on the latency-1 instance.
        for (int i = 0; i < 5; i++) begin
            do_txn(0, tbl[i].op, tbl[i].addr, tbl[i].wd, 0, 1'b0, 2'b00, 12'h0, 32'h0, grd, gwd);
            chk("tbl_rdata", grd, tbl[i].exp_rd);
            if (tbl[i].has_wr) chk("tbl_wdata", gwd, tbl[i].exp_wr);
        end

        // Back-pressure: response held 5 cycles while the next request waits on req_valid.
        do_txn(0, RD, 12'h010, 32'h0, 5, 1'b1, WRT, 12'h030, 32'h12345678, grd, gwd);
        do_txn(0, WRT, 12'h030, 32'h12345678, 0, 1'b0, 2'b00, 12'h0, 32'h0, grd, gwd);

        // Narrow counter wraps: 1,2,3,0.
        for (int i = 0; i < 4; i++)
            do_txn(1, WRT, 12'(12'h020 + (i == 0 ? 0 : 4 * i)), 32'hA5A500F0 + i, 0, 1'b0,
                   2'b00, 12'h0, 32'h0, grd, gwd);

        // Reset during RD_WAIT of a SET: aborted, no write ever appears.
        r0 = rd_cnt[1]; w0 = wr_cnt[1];
        drive_req(1, 1'b1, SETB, 12'h020, 32'h0000000F);
        @(posedge clk);
        @(negedge clk);
        drive_req(1, 1'b0, 2'b00, 12'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        mdl_cnt[1] = 0;
        chk_zero(1, "abort");
        chk("abort_req_ready", req_ready[1], 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort_no_write", wr_cnt[1] - w0, 0);
        chk("abort_one_read", rd_cnt[1] - r0, 1);
        chk("abort_no_rsp", rsp_valid[1], 0);
        do_txn(1, RD, 12'h020, 32'h0, 0, 1'b0, 2'b00, 12'h0, 32'h0, grd, gwd);
        chk("post_reset_read", grd, 32'hA5A500F0);

        // Randomized traffic on both instances over a small address window.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 25; i++) begin
                do_txn(d, 2'($urandom), 12'($urandom_range(0, 7) * 4), $urandom,
                       $urandom_range(0, 2), 1'b0, 2'b00, 12'h0, 32'h0, grd, gwd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
